// File: rtl/lbp_pkg.sv
// Shared types and the LBP uniform-pattern bin mapping for the histogram stage.
package lbp_pkg;

    localparam int unsigned LBP_NBINS      = 59;
    localparam int unsigned LBP_NONUNI_BIN = 58;
    localparam int unsigned LBP_BIN_W      = 6;
    localparam int unsigned LBP_CODE_W     = 8;
    localparam int unsigned LBP_ADDR_W     = 14;
    localparam int unsigned LBP_PIX_W      = 15;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } lbp_state_e;

    typedef struct packed {
        logic                 valid;
        logic [LBP_BIN_W-1:0] bin;
    } lbp_s1_t;

    // Bit transitions around the circular 8-bit code.
    function automatic logic [3:0] lbp_transitions(input logic [LBP_CODE_W-1:0] code);
        logic [LBP_CODE_W-1:0] x;
        x = code ^ {code[0], code[LBP_CODE_W-1:1]};
        return 4'($countones(x));
    endfunction

    // Rank among uniform codes; the loop bounds are constant so this folds to a compare table.
    function automatic logic [LBP_BIN_W-1:0] lbp_uniform_bin(input logic [LBP_CODE_W-1:0] code);
        logic [LBP_BIN_W-1:0] bin;
        logic [LBP_BIN_W-1:0] rank;
        bin  = LBP_BIN_W'(LBP_NONUNI_BIN);
        rank = '0;
        for (int v = 0; v < 256; v++) begin
            if (lbp_transitions(8'(v)) <= 4'd2) begin
                if (8'(v) == code) bin = rank;
                rank = rank + 6'd1;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Code stream in, histogram drain out; the block side uses the slave modport.
interface lbp_hist_if
    import lbp_pkg::*;
#(
    parameter int unsigned CNT_W = 14
);
    logic                  lbp_valid;
    logic [LBP_ADDR_W-1:0] lbp_addr;
    logic [LBP_CODE_W-1:0] lbp_data;
    logic                  finish;
    logic                  hist_valid;
    logic                  hist_ready;
    logic [LBP_BIN_W-1:0]  hist_bin;
    logic [CNT_W-1:0]      hist_count;
    logic [LBP_PIX_W-1:0]  pix_total;
    logic                  hist_done;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, pix_total, hist_done
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, pix_total, hist_done
    );
endinterface

// File: rtl/lbp_uniform_map.sv
// Combinational 8-bit LBP code to uniform-pattern bin mapper.
module lbp_uniform_map
    import lbp_pkg::*;
(
    input  logic [LBP_CODE_W-1:0] code_i,
    output logic [LBP_BIN_W-1:0]  bin_o_c
);

    always_comb bin_o_c = lbp_uniform_bin(code_i);

endmodule

// File: rtl/lbp_hist.sv
// Uniform-LBP histogram: two-stage accumulate, then drain 59 bins over valid/ready.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int unsigned CNT_W = 14,
    parameter int unsigned NBINS = LBP_NBINS
) (
    input  logic       clk,
    input  logic       reset,
    lbp_hist_if.slave  bus
);

    localparam logic [CNT_W-1:0]     CNT_MAX = '1;
    localparam logic [LBP_PIX_W-1:0] PIX_MAX = '1;
    localparam logic [LBP_BIN_W-1:0] LAST_BIN = LBP_BIN_W'(NBINS - 1);

    lbp_state_e           state_q, state_d;
    lbp_s1_t              s1_q, s1_d;
    logic [CNT_W-1:0]     bins_q [NBINS];
    logic [CNT_W-1:0]     bins_d [NBINS];
    logic [LBP_PIX_W-1:0] pix_q, pix_d;
    logic [LBP_BIN_W-1:0] ptr_q, ptr_d;
    logic                 hist_valid_q, hist_valid_d;
    logic [CNT_W-1:0]     hist_count_q, hist_count_d;
    logic                 hist_done_q, hist_done_d;
    logic [LBP_BIN_W-1:0] map_bin_c;
    logic                 unused_addr_c;

    // Pixel address only serves an external count cross-check.
    assign unused_addr_c = ^bus.lbp_addr;

    lbp_uniform_map u_map (
        .code_i  (bus.lbp_data),
        .bin_o_c (map_bin_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACCUM;
            s1_q         <= '0;
            pix_q        <= '0;
            ptr_q        <= '0;
            hist_valid_q <= 1'b0;
            hist_count_q <= '0;
            hist_done_q  <= 1'b0;
            for (int i = 0; i < int'(NBINS); i++) bins_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            pix_q        <= pix_d;
            ptr_q        <= ptr_d;
            hist_valid_q <= hist_valid_d;
            hist_count_q <= hist_count_d;
            hist_done_q  <= hist_done_d;
            bins_q       <= bins_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s1_d         = '0;
        bins_d       = bins_q;
        pix_d        = pix_q;
        ptr_d        = ptr_q;
        hist_valid_d = hist_valid_q;
        hist_count_d = hist_count_q;
        hist_done_d  = hist_done_q;

        // Stage 2 retires in any state, so the FLUSH cycle drains the last code.
        if (s1_q.valid) begin
            if (bins_q[s1_q.bin] != CNT_MAX) bins_d[s1_q.bin] = bins_q[s1_q.bin] + CNT_W'(1);
            if (pix_q != PIX_MAX) pix_d = pix_q + LBP_PIX_W'(1);
        end

        case (state_q)
            ST_ACCUM: begin
                s1_d.valid = bus.lbp_valid;
                s1_d.bin   = map_bin_c;
                if (bus.finish) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // bins_d already holds the retired increment for the first word.
                state_d      = ST_DRAIN;
                ptr_d        = '0;
                hist_valid_d = 1'b1;
                hist_count_d = bins_d[0];
            end
            ST_DRAIN: begin
                if (hist_valid_q && bus.hist_ready) begin
                    if (ptr_q == LAST_BIN) begin
                        state_d      = ST_DONE;
                        hist_valid_d = 1'b0;
                        hist_done_d  = 1'b1;
                    end else begin
                        ptr_d        = ptr_q + LBP_BIN_W'(1);
                        hist_count_d = bins_q[ptr_d];
                    end
                end
            end
            ST_DONE: begin
                hist_valid_d = 1'b0;
                hist_done_d  = 1'b1;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    assign bus.hist_valid = hist_valid_q;
    assign bus.hist_bin   = ptr_q;
    assign bus.hist_count = hist_count_q;
    assign bus.pix_total  = pix_q;
    assign bus.hist_done  = hist_done_q;

endmodule
